imem_boot_loader: RTL and testbench
===================================

# imem_boot_loader

Boot controller for the instruction memory of the single-cycle MIPS. It receives a program as an 8-bit byte stream over a valid/ready handshake and packs the bytes into 32-bit big-endian words. It writes those words sequentially into the instruction RAM write port, then releases the CPU from reset. While the CPU runs, it translates the PC byte address to the word-indexed fetch address.

## Interface
Parameters:
- `MEM_WORDS`, default 256: instruction memory depth in words.
- `ADDR_W`, default 8: word-address width, equal to log2(`MEM_WORDS`).
- `BOOT_RUN`, default 0: if 1, reset enters RUN directly so the CPU runs the preloaded ROM image.

Ports (clock and reset first):
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `load_start`  in  1  one-cycle request to (re)load a program.
- `byte_valid`  in  1  stream byte present.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `pc_addr`  in  32  CPU program counter (byte address).
- `fetch_addr`  out  `ADDR_W`  word read address, equal to `pc_addr[ADDR_W+1:2]`; combinational.
- `mem_we`  out  1  instruction RAM write strobe.
- `mem_waddr`  out  `ADDR_W`  write word address.
- `mem_wdata`  out  32  write word.
- `cpu_rst`  out  1  holds the CPU in reset; high in every state except RUN.
- `busy`  out  1  a load is in progress.
- `error`  out  1  header rejected.
- `words_loaded`  out  `ADDR_W+1`  count of words written in the current load.

## Operation
- **States:** IDLE, HDR_HI, HDR_LO, DATA, FLUSH, RUN, ERR.
- **Transfer rule:** a byte transfers on a rising edge where `byte_valid` and `byte_ready` are both 1. `byte_ready` is 1 only in HDR_HI, HDR_LO and DATA. `byte_data` is ignored otherwise.
- **IDLE:**
  - `load_start` moves to HDR_HI.
  - Entry also clears `words_loaded`, the byte index and `error`.
- **Header:** the header is a 16-bit word count N, sent big-endian.
  - HDR_HI latches N[15:8] and moves to HDR_LO.
  - HDR_LO latches N[7:0] and evaluates N on that same edge:
    - N = 0 moves to FLUSH.
    - N > `MEM_WORDS` moves to ERR.
    - Otherwise moves to DATA.
- **DATA:**
  - A 2-bit byte index counts 0..3. The first byte of each word goes to bits [31:24].
  - On the 4th byte: register `mem_we`=1, `mem_waddr`=`words_loaded`, and `mem_wdata`=the assembled word. Then increment `words_loaded` and clear the byte index.
  - When the incremented count equals N, move to FLUSH.
- **FLUSH:** lasts one cycle so the final write commits before release. It then moves to RUN.
- **RUN:**
  - `cpu_rst`=0.
  - `load_start` moves to HDR_HI; `cpu_rst` returns to 1 on that edge.
- **ERR:**
  - `error`=1, `cpu_rst`=1, `byte_ready`=0.
  - `load_start` moves to HDR_HI and clears `error`.
- **Ignored requests:** `load_start` is ignored in HDR_HI, HDR_LO, DATA and FLUSH.
- **Widths:** N is 16 bits; the comparison against `MEM_WORDS` is done at 16-bit width. `mem_waddr` is `words_loaded[ADDR_W-1:0]`. `words_loaded` reaches `MEM_WORDS` without wrap.

## Timing
- **Reset values:**
  - State is IDLE, or RUN if `BOOT_RUN`=1.
  - `cpu_rst`=1 (0 if `BOOT_RUN`).
  - `mem_we`=0, `mem_waddr`=0, `mem_wdata`=0, `words_loaded`=0, `busy`=0, `error`=0, `byte_ready`=0.
- **Registered outputs:** all outputs except `fetch_addr` are registered.
- **Write strobe:** `mem_we` is high for exactly one cycle, the cycle after the edge that accepted the 4th byte.
- **Back-to-back bytes:** one byte per cycle is sustained. A word costs 4 cycles and the write overlaps the next word's bytes.
- **Release latency:** the last byte is accepted at edge k. `mem_we`=1 and the state is FLUSH during cycle k..k+1. `cpu_rst` falls at edge k+2.
- **`busy`:** 1 in HDR_HI, HDR_LO, DATA and FLUSH.
- **Mid-load reset:** reset asserted mid-load returns immediately to the reset values; the partial write stream is abandoned.
- **Stalls:** `byte_valid` low for any number of cycles stalls without state change.

## Structure
- **Package `imem_boot_pkg`:**
  - state enum `boot_state_t`.
  - `HDR_W`=16.
  - `BYTES_PER_WORD`=4.
- **Sub-module `boot_word_pack`:** the shift register, byte index and word-complete pulse. It takes `clk`, `reset`, `push`, `byte_data`, `clear`, and produces `word` and `word_done`.
- **Top-level contents:** the FSM, the counter, the N compare and the `fetch_addr` slice.

## Test plan
- **Normal load:** reset, pulse `load_start`, stream 00 02 DE AD BE EF 01 23 45 67 with `byte_valid` held high.
  - Writes 0xDEADBEEF to address 0, then 0x01234567 to address 1.
  - `words_loaded`=2.
  - `cpu_rst` falls 2 cycles after the last byte.
- **Empty program:** header 00 00 → no `mem_we`, FLUSH, then RUN; `cpu_rst` falls 2 cycles after the header's low byte.
- **Oversize header:** header 01 01 (257) with `MEM_WORDS`=256 → ERR, `error`=1, `byte_ready`=0, and extra bytes are not accepted. A following `load_start` clears `error` and restarts the load.
- **Stall and ignore:** random `byte_valid` gaps, plus a `load_start` pulse mid-DATA → identical memory contents, and the pulse is ignored.
- **Run, reload and reset:**
  - In RUN, `pc_addr`=0x0000_0014 → `fetch_addr`=5.
  - `load_start` in RUN → `cpu_rst`=1 on the next edge.
  - Asserting `reset` mid-word → all outputs at reset values within the same cycle, with no clock edge needed.

Source files
------------

// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_boot_pkg;

   localparam int HDR_W          = 16;
   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      IDLE,
      HDR_HI,
      HDR_LO,
      DATA,
      FLUSH,
      RUN,
      ERR
   } boot_state_t;

endpackage

// File: rtl/boot_word_pack.sv
// Packs a byte stream into big-endian 32-bit words; word_done flags the
// push that carries the final byte of a word.
module boot_word_pack
   import imem_boot_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        push,
   input  logic [7:0]  byte_data,
   input  logic        clear,
   output logic [31:0] word,
   output logic        word_done
);

   logic [8*(BYTES_PER_WORD-1)-1:0] shift_q;
   logic [1:0]                      idx_q;

   // The last byte is not stored: it is merged combinationally so the word
   // can be registered by the caller on the same edge that accepts it.
   assign word      = {shift_q, byte_data};
   assign word_done = push && (idx_q == 2'(BYTES_PER_WORD - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift_q <= '0;
         idx_q   <= '0;
      end else if (clear) begin
         shift_q <= '0;
         idx_q   <= '0;
      end else if (push) begin
         shift_q <= {shift_q[8*(BYTES_PER_WORD-2)-1:0], byte_data};
         idx_q   <= idx_q + 2'd1;
      end
   end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed byte stream into instruction RAM, then releases the
// CPU from reset and maps its byte PC onto word fetch addresses.
module imem_boot_loader
   import imem_boot_pkg::*;
#(
   parameter int MEM_WORDS = 256,
   parameter int ADDR_W    = 8,
   parameter int BOOT_RUN  = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   input  logic [31:0]       pc_addr,
   output logic [ADDR_W-1:0] fetch_addr,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_rst,
   output logic              busy,
   output logic              error,
   output logic [ADDR_W:0]   words_loaded,
   output boot_state_t       state_dbg
);

   localparam logic [HDR_W-1:0] MEM_WORDS_N = HDR_W'(MEM_WORDS);
   localparam boot_state_t      RESET_STATE = (BOOT_RUN != 0) ? RUN : IDLE;

   boot_state_t      state_q, state_d;
   logic [7:0]       hdr_hi_q;
   logic [HDR_W-1:0] n_words_q;
   logic [HDR_W-1:0] hdr_n;
   logic [HDR_W-1:0] words_next;
   logic             xfer, push, start;
   logic             word_done;
   logic [31:0]      word;
   logic             ready_d, busy_d, error_d, cpu_rst_d;
   logic             unused_pc_bits;

   // Handshake: byte_data moves on a rising edge where byte_valid and
   // byte_ready are both high; byte_ready is registered and is only high
   // while a header or data byte is expected, so byte_valid never needs to
   // wait on it combinationally.
   assign xfer       = byte_valid && byte_ready;
   assign push       = xfer && (state_q == DATA);
   assign hdr_n      = {hdr_hi_q, byte_data};
   assign words_next = HDR_W'(words_loaded) + HDR_W'(1);
   assign start      = (state_d == HDR_HI) && (state_q != HDR_HI);

   assign fetch_addr     = pc_addr[ADDR_W+1:2];
   assign unused_pc_bits = ^{pc_addr[31:ADDR_W+2], pc_addr[1:0]};
   assign state_dbg      = state_q;

   boot_word_pack u_pack (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .byte_data (byte_data),
      .clear     (start),
      .word      (word),
      .word_done (word_done)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:   if (load_start) state_d = HDR_HI;
         HDR_HI: if (xfer) state_d = HDR_LO;
         HDR_LO: begin
            if (xfer) begin
               if (hdr_n == '0)              state_d = FLUSH;
               else if (hdr_n > MEM_WORDS_N) state_d = ERR;
               else                          state_d = DATA;
            end
         end
         DATA:   if (word_done && (words_next == n_words_q)) state_d = FLUSH;
         FLUSH:  state_d = RUN;
         RUN:    if (load_start) state_d = HDR_HI;
         ERR:    if (load_start) state_d = HDR_HI;
         default: state_d = IDLE;
      endcase

      ready_d = (state_d == HDR_HI) || (state_d == HDR_LO) || (state_d == DATA);
      busy_d  = ready_d || (state_d == FLUSH);
      error_d = (state_d == ERR);
      // Release waits one cycle in RUN so the FLUSH-cycle write has landed.
      cpu_rst_d = !((state_q == RUN) && (state_d == RUN));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= RESET_STATE;
         byte_ready <= 1'b0;
         busy       <= 1'b0;
         error      <= 1'b0;
         cpu_rst    <= (BOOT_RUN == 0);
      end else begin
         state_q    <= state_d;
         byte_ready <= ready_d;
         busy       <= busy_d;
         error      <= error_d;
         cpu_rst    <= cpu_rst_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hdr_hi_q     <= '0;
         n_words_q    <= '0;
         words_loaded <= '0;
         mem_we       <= 1'b0;
         mem_waddr    <= '0;
         mem_wdata    <= '0;
      end else begin
         mem_we <= word_done;
         if (xfer && (state_q == HDR_HI)) hdr_hi_q <= byte_data;
         if (xfer && (state_q == HDR_LO)) n_words_q <= hdr_n;
         if (start)          words_loaded <= '0;
         else if (word_done) words_loaded <= words_loaded + (ADDR_W+1)'(1);
         if (word_done) begin
            mem_waddr <= words_loaded[ADDR_W-1:0];
            mem_wdata <= word;
         end
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized bench for imem_boot_loader: a stream-level reference model and a
// write scoreboard are compared against the DUT on every falling edge.
module tb_imem_boot_loader;
  import imem_boot_pkg::*;

  localparam int MEM_WORDS = 256;
  localparam int ADDR_W    = 8;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic              load_start = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = '0;
  logic              byte_ready;
  logic [31:0]       pc_addr = '0;
  logic [ADDR_W-1:0] fetch_addr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic              cpu_rst;
  logic              busy;
  logic              error;
  logic [ADDR_W:0]   words_loaded;
  boot_state_t       state_dbg;

  imem_boot_loader #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W), .BOOT_RUN(0)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .pc_addr(pc_addr),
    .fetch_addr(fetch_addr), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .cpu_rst(cpu_rst), .busy(busy), .error(error),
    .words_loaded(words_loaded), .state_dbg(state_dbg)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [39:0] exp_q[$];
  logic [7:0] norm_prog [10] = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                                 8'h01, 8'h23, 8'h45, 8'h67};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: tracks the load in terms of bytes received
  bit          m_loading = 0, m_flush = 0, m_run = 0, m_err = 0, was_run = 0;
  int          m_hdr_cnt = 0, m_n = 0, m_bytes = 0;
  logic [31:0] m_word = '0;
  logic        e_ready = 0, e_busy = 0, e_err = 0, e_cpu_rst = 1, e_we = 0;
  logic [7:0]  e_waddr = '0;
  logic [31:0] e_wdata = '0;
  int          e_words = 0;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_loading = 0; m_flush = 0; m_run = 0; m_err = 0;
      m_hdr_cnt = 0; m_n = 0; m_bytes = 0; m_word = '0;
      e_ready = 0; e_busy = 0; e_err = 0; e_cpu_rst = 1; e_we = 0;
      e_waddr = '0; e_wdata = '0; e_words = 0;
    end else begin
      was_run = m_run;
      e_we = 0;
      if (m_flush) begin
        m_flush = 0;
        m_run = 1;
      end else if (m_loading) begin
        if (byte_valid) begin
          if (m_hdr_cnt == 0) begin
            m_n = int'(byte_data) * 256;
            m_hdr_cnt = 1;
          end else if (m_hdr_cnt == 1) begin
            m_n = m_n + int'(byte_data);
            m_hdr_cnt = 2;
            if (m_n == 0) begin
              m_loading = 0; m_flush = 1;
            end else if (m_n > MEM_WORDS) begin
              m_loading = 0; m_err = 1;
            end
          end else begin
            m_word = {m_word[23:0], byte_data};
            m_bytes++;
            if (m_bytes % 4 == 0) begin
              e_we = 1;
              e_waddr = 8'(m_bytes / 4 - 1);
              e_wdata = m_word;
              if (m_bytes / 4 == m_n) begin
                m_loading = 0; m_flush = 1;
              end
            end
          end
        end
      end else if (load_start) begin
        m_loading = 1; m_hdr_cnt = 0; m_bytes = 0; m_err = 0; m_run = 0;
      end
      e_ready   = m_loading;
      e_busy    = m_loading || m_flush;
      e_err     = m_err;
      e_cpu_rst = !(m_run && was_run);
      e_words   = m_bytes / 4;
    end
  end

  // compare process + write scoreboard
  initial forever begin
    logic [39:0] item;
    @(negedge clk);
    chk("byte_ready", 64'(byte_ready), 64'(e_ready));
    chk("busy", 64'(busy), 64'(e_busy));
    chk("error", 64'(error), 64'(e_err));
    chk("cpu_rst", 64'(cpu_rst), 64'(e_cpu_rst));
    chk("mem_we", 64'(mem_we), 64'(e_we));
    chk("mem_waddr", 64'(mem_waddr), 64'(e_waddr));
    chk("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
    chk("words_loaded", 64'(words_loaded), 64'(e_words));
    chk("fetch_addr", 64'(fetch_addr), 64'((pc_addr >> 2) % 32'(MEM_WORDS)));
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_write", 64'(mem_we), 64'(0));
      end else begin
        item = exp_q.pop_front();
        chk("sb_addr", 64'(mem_waddr), 64'(item[39:32]));
        chk("sb_data", 64'(mem_wdata), 64'(item[31:0]));
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached before completion, expected summary");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    pc_addr = $urandom();
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    bit done;
    logic rdy;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (gap) begin
      byte_valid = 1'b0;
      byte_data = 8'($urandom());
      tick();
    end
    byte_valid = 1'b1;
    byte_data = b;
    done = 0;
    for (int t = 0; t < 64 && !done; t++) begin
      @(negedge clk);
      rdy = byte_ready;
      tick();
      if (rdy === 1'b1) done = 1;
    end
    if (!done) chk("byte_accept_timeout", 64'(0), 64'(1));
    byte_valid = 1'b0;
  endtask

  task automatic send_words(input int n, input int max_gap, input bit mid);
    logic [15:0] n16;
    logic [31:0] w;
    n16 = 16'(n);
    send_byte(n16[15:8], max_gap);
    send_byte(n16[7:0], max_gap);
    for (int i = 0; i < n; i++) begin
      w = $urandom();
      exp_q.push_back({8'(i), w});
      if (mid && i == 1) begin
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
      end
      for (int j = 0; j < 4; j++) send_byte(w[31-8*j -: 8], max_gap);
    end
  endtask

  task automatic wait_release(output int lat);
    lat = 0;
    while (cpu_rst !== 1'b0 && lat < 50) begin
      tick();
      lat++;
    end
    if (cpu_rst !== 1'b0) chk("release_timeout", 64'(cpu_rst), 64'(0));
  endtask

  initial begin
    int lat;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_rst", 64'(cpu_rst), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_byte_ready", 64'(byte_ready), 64'(0));
    chk("rst_mem_we", 64'(mem_we), 64'(0));
    reset = 1'b0;
    tick();

    // normal load with literal words
    exp_q.push_back({8'h00, 32'hDEADBEEF});
    exp_q.push_back({8'h01, 32'h01234567});
    start_load();
    for (int i = 0; i < 10; i++) send_byte(norm_prog[i], 0);
    wait_release(lat);
    chk("norm_release_latency", 64'(lat), 64'(2));
    chk("norm_words_loaded", 64'(words_loaded), 64'(2));
    pc_addr = 32'h0000_0014;
    #1;
    chk("fetch_addr_0x14", 64'(fetch_addr), 64'(5));

    // reload from RUN, then empty program
    chk("run_cpu_rst_low", 64'(cpu_rst), 64'(0));
    start_load();
    chk("reload_cpu_rst_high", 64'(cpu_rst), 64'(1));
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    wait_release(lat);
    chk("empty_release_latency", 64'(lat), 64'(2));
    chk("empty_words_loaded", 64'(words_loaded), 64'(0));

    // oversize header 257 words
    start_load();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    tick();
    chk("oversize_error", 64'(error), 64'(1));
    chk("oversize_byte_ready", 64'(byte_ready), 64'(0));
    repeat (5) begin
      byte_valid = 1'b1;
      byte_data = 8'($urandom());
      tick();
    end
    byte_valid = 1'b0;
    chk("oversize_words_loaded", 64'(words_loaded), 64'(0));
    start_load();
    chk("err_cleared", 64'(error), 64'(0));
    send_words(3, 2, 0);
    wait_release(lat);

    // stalls plus an ignored load_start mid-DATA on the literal program
    exp_q.push_back({8'h00, 32'hDEADBEEF});
    exp_q.push_back({8'h01, 32'h01234567});
    start_load();
    for (int i = 0; i < 10; i++) begin
      if (i == 6) begin
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
      end
      send_byte(norm_prog[i], 3);
    end
    wait_release(lat);
    chk("stall_words_loaded", 64'(words_loaded), 64'(2));

    // full memory: N == MEM_WORDS
    start_load();
    send_words(MEM_WORDS, 0, 0);
    wait_release(lat);
    chk("full_words_loaded", 64'(words_loaded), 64'(MEM_WORDS));

    // random programs
    repeat (6) begin
      start_load();
      send_words(int'($urandom_range(12, 1)), 3, 1'($urandom_range(1, 0)));
      wait_release(lat);
    end

    // asynchronous reset in the middle of the second word
    start_load();
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    begin
      logic [31:0] w0;
      w0 = $urandom();
      exp_q.push_back({8'h00, w0});
      for (int j = 0; j < 4; j++) send_byte(w0[31-8*j -: 8], 0);
    end
    send_byte(8'($urandom()), 0);
    send_byte(8'($urandom()), 0);
    chk("pre_reset_words_loaded", 64'(words_loaded), 64'(1));
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_byte_ready", 64'(byte_ready), 64'(0));
    chk("async_rst_busy", 64'(busy), 64'(0));
    chk("async_rst_error", 64'(error), 64'(0));
    chk("async_rst_cpu_rst", 64'(cpu_rst), 64'(1));
    chk("async_rst_mem_we", 64'(mem_we), 64'(0));
    chk("async_rst_mem_waddr", 64'(mem_waddr), 64'(0));
    chk("async_rst_mem_wdata", 64'(mem_wdata), 64'(0));
    chk("async_rst_words_loaded", 64'(words_loaded), 64'(0));
    tick();
    tick();
    reset = 1'b0;
    tick();

    start_load();
    send_words(2, 1, 0);
    wait_release(lat);
    repeat (3) tick();

    chk("exp_q_drained", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
